// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer for the processor core.
//
// Drives the status register's exception (push) and rfe (pop) strobes. At commit it
// arbitrates illegal instructions, privilege violations, syscalls, returns and external
// interrupts. It captures EPC and cause, flushes the pipeline and redirects fetch to the
// handler vector, or back to EPC on a return.
//
// Optional feature: define EXC_CTRL_IRQ_EN to compile in the interrupt source. In that build
// cause[8 +: NIRQ] carries an irq snapshot. Without it, irq and ie are ignored, code 0 is
// never produced and cause[15:8] stays 0.
//
// Parameters:
//   VEC_ADDR  handler entry PC
//   NIRQ      number of level-sensitive interrupt lines (1..8)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   irq        level interrupt requests
//   ie         interrupt enable from the status register
//   su         1 = supervisor mode
//   ill_req    illegal instruction at commit
//   sys_req    syscall at commit
//   priv_op    privileged instruction at commit (includes rfe)
//   rfe_req    rfe instruction at commit
//   pc_cur     PC of the committing instruction
//   exception  one-cycle push strobe to the status register
//   rfe        one-cycle pop strobe to the status register
//   flush      kill all in-flight instructions
//   pc_load    fetch redirect valid
//   pc_next    fetch redirect target (0 when pc_load is 0)
//   epc        saved return PC
//   cause      saved cause
//   busy       stall commit
module exc_ctrl #(
  parameter logic [31:0] VEC_ADDR = 32'h0000_0080,
  parameter int unsigned NIRQ     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            ie,
  input  logic            su,
  input  logic            ill_req,
  input  logic            sys_req,
  input  logic            priv_op,
  input  logic            rfe_req,
  input  logic [31:0]     pc_cur,
  output logic            exception,
  output logic            rfe,
  output logic            flush,
  output logic            pc_load,
  output logic [31:0]     pc_next,
  output logic [31:0]     epc,
  output logic [31:0]     cause,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StTake, StVect, StRet} state_e;

  localparam logic [4:0] CodeIrq  = 5'd0;
  localparam logic [4:0] CodeSys  = 5'd1;
  localparam logic [4:0] CodeIll  = 5'd2;
  localparam logic [4:0] CodePriv = 5'd3;

  state_e      state_q, state_d;
  logic [4:0]  code;
  logic        irq_pend;
  logic [31:0] cause_d;

  logic        exception_q, rfe_q, flush_q, pc_load_q, busy_q;
  logic [31:0] pc_next_q, epc_q, cause_q;

`ifdef EXC_CTRL_IRQ_EN
  assign irq_pend = (|irq) & ie;
`else
  // Interrupt source compiled out; the port stays so the top level is unchanged.
  logic unused_irq;
  assign unused_irq = ^{irq, ie};
  assign irq_pend   = 1'b0;
`endif

  // Next-state and priority arbitration. Requests are only looked at in StIdle; in every
  // other state busy holds them back in the pipeline.
  always_comb begin
    state_d = state_q;
    code    = CodeIrq;
    unique case (state_q)
      StIdle: begin
        if (ill_req) begin
          state_d = StTake;
          code    = CodeIll;
        end else if (priv_op && !su) begin
          // A user-mode rfe lands here, never on the return path.
          state_d = StTake;
          code    = CodePriv;
        end else if (sys_req) begin
          state_d = StTake;
          code    = CodeSys;
        end else if (rfe_req && su) begin
          state_d = StRet;
        end else if (irq_pend) begin
          state_d = StTake;
          code    = CodeIrq;
        end
      end
      StTake:  state_d = StVect;
      StVect:  state_d = StIdle;
      StRet:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Cause word captured on exception entry.
  always_comb begin
    cause_d = {27'b0, code};
`ifdef EXC_CTRL_IRQ_EN
    cause_d[8 +: NIRQ] = irq;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the next state and registered, so each strobe lines up with
  // the state it belongs to and nothing depends combinationally on inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exception_q <= 1'b0;
      rfe_q       <= 1'b0;
      flush_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      pc_next_q   <= 32'h0;
    end else begin
      exception_q <= (state_d == StTake);
      rfe_q       <= (state_d == StRet);
      flush_q     <= (state_d == StTake) || (state_d == StRet);
      pc_load_q   <= (state_d == StVect) || (state_d == StRet);
      busy_q      <= (state_d != StIdle);
      if (state_d == StVect) begin
        pc_next_q <= VEC_ADDR;
      end else if (state_d == StRet) begin
        // epc is never written on the return path, so the current value is the target.
        pc_next_q <= epc_q;
      end else begin
        pc_next_q <= 32'h0;
      end
    end
  end

  // EPC and cause only change on exception entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q   <= 32'h0;
      cause_q <= 32'h0;
    end else if (state_q == StIdle && state_d == StTake) begin
      epc_q   <= pc_cur;
      cause_q <= cause_d;
    end
  end

  assign exception = exception_q;
  assign rfe       = rfe_q;
  assign flush     = flush_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign busy      = busy_q;

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception sequencer for the processor core: the block that drives the status register's `exception` and `rfe` strobes. It arbitrates synchronous faults, syscalls and external interrupts at commit, captures EPC and cause, flushes the pipeline and redirects fetch to the handler vector. On `rfe`, it pulses the status-register pop and returns fetch to EPC.

## Interface
- `VEC_ADDR`, default 32'h0000_0080: handler entry PC.
- `NIRQ`, default 4: number of level-sensitive interrupt lines, 1..8.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `irq` in NIRQ: level interrupt requests.
- `ie` in 1: interrupt enable from the status register's `IE_c`.
- `su` in 1: mode from the status register's `s_u_c`. 1 means supervisor.
- `ill_req` in 1: illegal instruction at commit.
- `sys_req` in 1: syscall at commit.
- `priv_op` in 1: privileged instruction at commit. Includes rfe.
- `rfe_req` in 1: rfe instruction at commit.
- `pc_cur` in 32: PC of the committing instruction.
- `exception` out 1: one-cycle push strobe to the status register.
- `rfe` out 1: one-cycle pop strobe to the status register.
- `flush` out 1: kill all in-flight instructions.
- `pc_load` out 1, `pc_next` out 32: fetch redirect.
- `epc` out 32: saved return PC.
- `cause` out 32: saved cause.
- `busy` out 1: stall commit.

## Operation
- States are IDLE, TAKE, VECT and RET.
- Requests are sampled only in IDLE. Requests arriving in any other state are ignored; the pipeline holds them because `busy` is high.
- Priority, highest first:
  - `ill_req`: code 2.
  - `priv_op & !su`: code 3, privilege violation.
  - `sys_req`: code 1.
  - `rfe_req & su`: return.
  - `|irq & ie`: code 0.
- An rfe in user mode is a privilege violation, never a return.
- Exception path, IDLE to TAKE to VECT to IDLE:
  - On entry to TAKE, the block registers `epc <= pc_cur` and `cause[4:0] <= code`.
  - `cause[8+NIRQ-1:8] <= irq` snapshot. All other `cause` bits are 0.
  - TAKE asserts `exception` and `flush`.
  - VECT asserts `pc_load` with `pc_next = VEC_ADDR`.
- Return path, IDLE to RET to IDLE:
  - RET asserts `rfe`, `flush` and `pc_load` with `pc_next = epc`.
  - `epc` and `cause` are unchanged.
- The block never asserts `exception` and `rfe` in the same cycle.
- `epc` and `cause` hold their values until the next exception entry.
- `busy` is 1 in TAKE, VECT and RET, and 0 in IDLE.
- `pc_next` is 0 whenever `pc_load` is 0.

## Timing
- Reset drives state to IDLE. `exception`, `rfe`, `flush`, `pc_load` and `busy` go to 0. `pc_next`, `epc` and `cause` go to 32'h0.
- Reset asserted mid-sequence returns to IDLE immediately. No strobe is completed after reset.
- Exception latency, with a request in IDLE in cycle N:
  - Cycle N+1: `exception` and `flush` are high.
  - Cycle N+2: `pc_load` is high.
  - Cycle N+3: IDLE, ready for a new request.
- Return latency, with a request in cycle N:
  - Cycle N+1: `rfe`, `flush` and `pc_load` are high.
  - Cycle N+2: IDLE.
- All outputs are registered. None depends combinationally on inputs.
- Simultaneous requests resolve strictly by the priority order above. A losing request is dropped; the flush discards it.
- `ie` and `su` are sampled in IDLE only.
  - The status register updates them on the strobe edge.
  - The new values are therefore valid by the time the next request is sampled.
- Back-to-back exceptions are legal: the first cycle of IDLE may accept a new request.

## Configuration
- `EXC_CTRL_IRQ_EN` defined:
  - The interrupt source is compiled in.
  - `cause[15:8]` carries the irq snapshot.
- `EXC_CTRL_IRQ_EN` not defined:
  - `irq` and `ie` are ignored and code 0 is never produced.
  - `cause[15:8]` is always 0.
  - The `irq` port is still present so the top level is unchanged.

## Test plan
- Reset with `rst=0` for 2 cycles, then release -> all outputs 0, IDLE, `busy=0`.
- `ill_req=1`, `sys_req=1`, `pc_cur=32'h100` -> TAKE then VECT:
  - `epc=32'h100`, `cause=2`.
  - `exception` high exactly 1 cycle.
  - `pc_next=32'h80` on the load cycle.
- `rfe_req=1`, `priv_op=1`, `su=1`, `epc=32'h100` -> 1-cycle `rfe`, `pc_load`, `pc_next=32'h100`, no `exception`.
- Same rfe with `su=0` -> exception with `cause=3`, `rfe` stays 0.
- `irq=4'b0100`, `ie=1` -> `cause=32'h0000_0400`.
  - With `ie=0` -> no action.
  - With macro undefined -> no action.
- `rst` pulled low in VECT -> `pc_load` not asserted, outputs 0, and a later `sys_req` is serviced normally.
